id_ex_pipe_reg: RTL
===================

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of register-file and immediate fields.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have FlushE  input  1  hazard-unit flush; inserts bubble into Execute.
REQ-005 SHALL have ValidD  input  1  Decode holds a real instruction.
REQ-006 SHALL have RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  input  1 each  decode control bits.
REQ-007 SHALL have ALUControlD  input  3  ALU operation.
REQ-008 SHALL have RD1D, RD2D, SignImmD  input  WIDTH each  operands and sign-extended immediate.
REQ-009 SHALL have RsD, RtD, RdD  input  5 each  register specifiers.
REQ-010 SHALL have registered E-stage copies of every REQ-006..REQ-009 signal, each output, same width, suffix E.
REQ-011 SHALL have ValidE  output  1  Execute holds a real instruction.
REQ-012 SHALL have WriteRegE  output  5  Execute destination register, fed to hazard unit.
REQ-013 SHALL have BubbleCntE  output  16  bubbles inserted since reset (present only with macro, REQ-027).

Function
REQ-014 SHALL capture all D inputs into E registers on every rising clk edge when FlushE=0 and ValidD=1; latency exactly one cycle.
REQ-015 SHALL, when FlushE=1 or ValidD=0, load a bubble: ValidE=0, RegWriteE=0, MemtoRegE=0, MemWriteE=0, ALUSrcE=0, RegDstE=0, ALUControlE=0, RsE=RtE=RdE=0, RD1E=RD2E=SignImmE=0.
REQ-016 SHALL give FlushE priority over ValidD=1 in the same cycle (bubble loaded, instruction discarded).
REQ-017 SHALL have no stall/hold: a new value (instruction or bubble) loads every cycle.
REQ-018 SHALL drive WriteRegE combinationally from registered state: RdE when RegDstE=1, else RtE.
REQ-019 SHALL force WriteRegE=0 whenever ValidE=0 or RegWriteE=0, so bubbles never match a hazard comparison against a nonzero register.
REQ-020 SHALL treat register 0 as ordinary data in capture; no special-casing beyond REQ-019.
REQ-021 SHALL never produce RegWriteE=1 or MemWriteE=1 while ValidE=0.
REQ-022 SHALL keep consecutive FlushE cycles each loading a bubble; no internal flush counting or extension.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously clear every E register to the bubble state of REQ-015 (ValidE=0, WriteRegE=0) without waiting for clk.
REQ-024 SHALL hold bubble state while rst_n=0 regardless of D inputs and FlushE.
REQ-025 SHALL capture normally on the first rising edge after rst_n deasserts.
REQ-026 SHALL abandon any in-flight instruction if reset asserts mid-operation; no partial state survives.

Configuration
REQ-027 SHALL, with macro ID_EX_BUBBLE_CNT_EN defined, implement BubbleCntE: reset 0, increments by 1 on each edge that loads a bubble (REQ-015), saturates at 16'hFFFF.
REQ-028 SHALL, without ID_EX_BUBBLE_CNT_EN, omit the BubbleCntE port and counter entirely; all other behaviour identical.

Verification
REQ-029 Capture: ValidD=1, RegWriteD=1, RegDstD=1, RsD=5, RtD=6, RdD=7, RD1D=32'h1234 -> next edge ValidE=1, RsE=5, RtE=6, WriteRegE=7, RD1E=32'h1234.
REQ-030 RegDst select: same but RegDstD=0 -> WriteRegE=6; RegWriteD=0 -> WriteRegE=0.
REQ-031 Flush priority: FlushE=1 with ValidD=1, MemWriteD=1, RtD=9 -> next edge ValidE=0, MemWriteE=0, RtE=0, WriteRegE=0; next cycle FlushE=0 captures normally.
REQ-032 Async reset: ValidE=1, RegWriteE=1, then rst_n=0 between edges -> ValidE=0, RegWriteE=0 immediately; held until rst_n=1 and next edge.
REQ-033 Counter (ID_EX_BUBBLE_CNT_EN): 3 FlushE cycles plus 2 ValidD=0 cycles -> BubbleCntE=5; preload near 16'hFFFF -> stays 16'hFFFF on further bubbles.
REQ-034 Back-to-back: alternating FlushE 1/0 for 8 cycles with ValidD=1 -> ValidE sequence 0,1,0,1,... one cycle behind FlushE.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - Decode-to-Execute pipeline register with flush/bubble insertion.
// Optional bubble counter output BubbleCntE is enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             ALUSrcD,
    input  logic             RegDstD,
    input  logic [2:0]       ALUControlD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] SignImmD,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RdD,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             MemWriteE,
    output logic             ALUSrcE,
    output logic             RegDstE,
    output logic [2:0]       ALUControlE,
    output logic [WIDTH-1:0] RD1E,
    output logic [WIDTH-1:0] RD2E,
    output logic [WIDTH-1:0] SignImmE,
    output logic [4:0]       RsE,
    output logic [4:0]       RtE,
    output logic [4:0]       RdE,
    output logic             ValidE,
    output logic [4:0]       WriteRegE
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]      BubbleCntE
`endif
);

    // Flush wins over a valid instruction; an empty Decode slot also becomes a bubble.
    logic loadBubble;
    assign loadBubble = FlushE | ~ValidD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= 3'd0;
            RD1E        <= '0;
            RD2E        <= '0;
            SignImmE    <= '0;
            RsE         <= 5'd0;
            RtE         <= 5'd0;
            RdE         <= 5'd0;
        end else if (loadBubble) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= 3'd0;
            RD1E        <= '0;
            RD2E        <= '0;
            SignImmE    <= '0;
            RsE         <= 5'd0;
            RtE         <= 5'd0;
            RdE         <= 5'd0;
        end else begin
            ValidE      <= 1'b1;
            RegWriteE   <= RegWriteD;
            MemtoRegE   <= MemtoRegD;
            MemWriteE   <= MemWriteD;
            ALUSrcE     <= ALUSrcD;
            RegDstE     <= RegDstD;
            ALUControlE <= ALUControlD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            SignImmE    <= SignImmD;
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= RdD;
        end
    end

    // Bubbles and non-writing instructions report r0 so they never create a false hazard.
    assign WriteRegE = (ValidE && RegWriteE) ? (RegDstE ? RdE : RtE) : 5'd0;

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BubbleCntE <= 16'd0;
        end else if (loadBubble && (BubbleCntE != 16'hFFFF)) begin
            BubbleCntE <= BubbleCntE + 16'd1;
        end
    end
`endif

endmodule
